// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default geometry for the 16x8 RAM bank, its access
// controller and the display logic that reads from it.
package ram_access_ctrl_pkg;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrated, fixed-latency access sequencer for one synchronous RAM bank
// shared by the switch-entry writer and the display scanner.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int AW     = RAM_AW,
    parameter int DW     = RAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    grant_q, grant_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          we_q, we_d;
    logic [1:0]    pick;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant_d = grant_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        busy_d  = busy_q;
        we_d    = we_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ST_ISSUE;
                    grant_d = pick;
                    busy_d  = 1'b1;
                    wr_d    = pick[1] ? wr1 : wr0;
                    addr_d  = pick[1] ? addr1 : addr0;
                    wdata_d = pick[1] ? wdata1 : wdata0;
                    // Enable is registered here so it is high exactly in ISSUE
                    we_d    = pick[1] ? wr1 : wr0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                we_d    = 1'b0;
                cnt_d   = WAIT_INIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_ACK;
                    if (!wr_q) begin
                        rdata_d = ram_rdata;
                    end
                    ack0_d = grant_q[0];
                    ack1_d = grant_q[1];
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                last_d  = grant_q[1];
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            grant_q <= 2'b00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign ram_we    = we_q;
    assign ram_waddr = addr_q;
    assign ram_raddr = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: one RD_LAT=1 instance and one
// RD_LAT=3 instance, each backed by a small synchronous RAM model.
module tb_ram_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, ram_we;
    logic [1:0]    grant;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_waddr, ram_raddr;

    logic          b_req0 = 0, b_req1 = 0, b_wr0 = 0, b_wr1 = 0;
    logic [AW-1:0] b_addr0 = '0, b_addr1 = '0;
    logic [DW-1:0] b_wdata0 = '0, b_wdata1 = '0;
    logic          b_ack0, b_ack1, b_busy, b_ram_we;
    logic [1:0]    b_grant;
    logic [DW-1:0] b_rdata, b_ram_wdata, b_ram_rdata;
    logic [AW-1:0] b_ram_waddr, b_ram_raddr;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [3];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 8'h10 + 8'(i);
                mem_b[i] <= 8'h20 + 8'(i);
            end
        end else begin
            if (ram_we) mem_a[ram_waddr] <= ram_wdata;
            if (b_ram_we) mem_b[b_ram_waddr] <= b_ram_wdata;
        end
        pipe_a    <= mem_a[ram_raddr];
        pipe_b[0] <= mem_b[b_ram_raddr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign ram_rdata   = pipe_a;
    assign b_ram_rdata = pipe_b[2];

    ram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .grant(grant), .busy(busy), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(b_req1), .wr0(b_wr0), .wr1(b_wr1),
        .addr0(b_addr0), .addr1(b_addr1),
        .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
        .grant(b_grant), .busy(b_busy), .ram_we(b_ram_we),
        .ram_waddr(b_ram_waddr), .ram_raddr(b_ram_raddr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload = 1'b1;
        step();
        step();
        preload = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if ({ack0, ack1, grant, busy, ram_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {ack0, ack1, grant, busy, ram_we});
        end
        checks++;
        if ({ram_waddr, ram_raddr, ram_wdata, rdata} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000",
                     {ram_waddr, ram_raddr, ram_wdata, rdata});
        end
        checks++;
        if ({b_ack0, b_ack1, b_grant, b_busy, b_ram_we, b_rdata} !== 14'h0) begin
            failures++;
            $display("FAIL reset_lat3 got=%h exp=0",
                     {b_ack0, b_ack1, b_grant, b_busy, b_ram_we, b_rdata});
        end
    endtask

    task automatic test_write();
        int we_cnt = 0;
        int ack_k = 0;
        req0 = 1; wr0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
        step();
        checks++;
        if ({grant, ram_we, ram_waddr, ram_wdata} !== {2'b01, 1'b1, 4'd3, 8'hA5}) begin
            failures++;
            $display("FAIL write_issue got=%h exp=%h",
                     {grant, ram_we, ram_waddr, ram_wdata},
                     {2'b01, 1'b1, 4'd3, 8'hA5});
        end
        addr0 = 4'd9; wdata0 = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (ram_we) we_cnt++;
            if (ack0 && ack_k == 0) begin
                ack_k = k;
                req0 = 0;
            end
        end
        checks++;
        if (we_cnt != 1) begin
            failures++;
            $display("FAIL write_we_cycles got=%0d exp=1", we_cnt);
        end
        checks++;
        if (ack_k != 3) begin
            failures++;
            $display("FAIL write_ack_cycle got=%0d exp=3", ack_k);
        end
        checks++;
        if (mem_a[3] !== 8'hA5 || mem_a[9] !== 8'h19) begin
            failures++;
            $display("FAIL write_ram got=%h/%h exp=a5/19", mem_a[3], mem_a[9]);
        end
        checks++;
        if (busy !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL write_after got=%b/%h exp=0/00", busy, rdata);
        end
    endtask

    task automatic test_readback();
        int ack_k = 0;
        logic seen0 = 1'b0;
        logic [1:0] g1 = 2'b00;
        logic [DW-1:0] rd = '0;
        req1 = 1; wr1 = 0; addr1 = 4'd3;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (k == 1) g1 = grant;
            if (ack0) seen0 = 1'b1;
            if (ack1 && ack_k == 0) begin
                ack_k = k;
                rd = rdata;
                req1 = 0;
            end
        end
        checks++;
        if (g1 !== 2'b10) begin
            failures++;
            $display("FAIL readback_grant got=%b exp=10", g1);
        end
        checks++;
        if (ack_k != 3 || rd !== 8'hA5) begin
            failures++;
            $display("FAIL readback_data got=%0d/%h exp=3/a5", ack_k, rd);
        end
        checks++;
        if (seen0 !== 1'b0) begin
            failures++;
            $display("FAIL readback_ack0 got=%b exp=0", seen0);
        end
    endtask

    task automatic test_tie(input int first);
        int k0 = 0;
        int k1 = 0;
        logic [1:0] g1 = 2'b00;
        logic [1:0] g5 = 2'b00;
        logic b5 = 1'b0;
        logic [DW-1:0] rd0 = '0;
        logic [DW-1:0] rd1 = '0;
        req0 = 1; wr0 = 0; addr0 = 4'd3;
        req1 = 1; wr1 = 0; addr1 = 4'd5;
        step();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            if (k == 1) g1 = grant;
            if (k == 5) begin
                g5 = grant;
                b5 = busy;
            end
            if (ack0 && k0 == 0) begin
                k0 = k; rd0 = rdata; req0 = 0;
            end
            if (ack1 && k1 == 0) begin
                k1 = k; rd1 = rdata; req1 = 0;
            end
        end
        checks++;
        if (g1 !== (first == 1 ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL tie%0d_first_grant got=%b", first, g1);
        end
        checks++;
        if (g5 !== (first == 1 ? 2'b01 : 2'b10) || b5 !== 1'b1) begin
            failures++;
            $display("FAIL tie%0d_second_grant got=%b busy=%b", first, g5, b5);
        end
        checks++;
        if (k0 != (first == 1 ? 7 : 3) || k1 != (first == 1 ? 3 : 7)) begin
            failures++;
            $display("FAIL tie%0d_ack_cycles got=%0d,%0d", first, k0, k1);
        end
        checks++;
        if (rd0 !== 8'hA5 || rd1 !== 8'h15) begin
            failures++;
            $display("FAIL tie%0d_rdata got=%h,%h exp=a5,15", first, rd0, rd1);
        end
    endtask

    task automatic test_single_read();
        int ack_k = 0;
        logic [DW-1:0] rd = '0;
        req0 = 1; wr0 = 0; addr0 = 4'd0;
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            if (ack0 && ack_k == 0) begin
                ack_k = k; rd = rdata; req0 = 0;
            end
        end
        checks++;
        if (ack_k != 3 || rd !== 8'h10) begin
            failures++;
            $display("FAIL single_read got=%0d/%h exp=3/10", ack_k, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        int ack_k = 0;
        logic [DW-1:0] rd = '0;
        req0 = 1; wr0 = 1; addr0 = 4'd7; wdata0 = 8'hFF;
        step();
        checks++;
        if (ram_we !== 1'b1) begin
            failures++;
            $display("FAIL midrst_issue got=%b exp=1", ram_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, grant, ram_we, ack0, rdata} !== 13'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h exp=0",
                     {busy, grant, ram_we, ack0, rdata});
        end
        req0 = 0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ack0 || ack1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_noack got=%b/%b exp=0/0", seen, busy);
        end
        req1 = 1; wr1 = 0; addr1 = 4'd7;
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            if (ack1 && ack_k == 0) begin
                ack_k = k; rd = rdata; req1 = 0;
            end
        end
        checks++;
        if (ack_k != 3 || rd !== 8'h17) begin
            failures++;
            $display("FAIL midrst_readback got=%0d/%h exp=3/17", ack_k, rd);
        end
    endtask

    task automatic test_conflict();
        int k0 = 0;
        int k1 = 0;
        logic [DW-1:0] rd = '0;
        req0 = 1; wr0 = 1; addr0 = 4'd15; wdata0 = 8'h3C;
        req1 = 1; wr1 = 0; addr1 = 4'd15;
        step();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            if (ack0 && k0 == 0) begin
                k0 = k; req0 = 0;
            end
            if (ack1 && k1 == 0) begin
                k1 = k; rd = rdata; req1 = 0;
            end
        end
        checks++;
        if (k0 != 3 || k1 != 7) begin
            failures++;
            $display("FAIL conflict_order got=%0d,%0d exp=3,7", k0, k1);
        end
        checks++;
        if (rd !== 8'h3C) begin
            failures++;
            $display("FAIL conflict_rdata got=%h exp=3c", rd);
        end
    endtask

    task automatic test_lat3();
        int ack_k = 0;
        int we_cnt = 0;
        int we_late = 0;
        logic [DW-1:0] rd = '0;
        b_req0 = 1; b_wr0 = 1; b_addr0 = 4'd2; b_wdata0 = 8'h77;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (b_ram_we) we_cnt++;
            if (b_ack0 && ack_k == 0) begin
                ack_k = k; b_req0 = 0;
            end
        end
        checks++;
        if (ack_k != 5 || we_cnt != 1 || b_rdata !== 8'h00) begin
            failures++;
            $display("FAIL lat3_write got=%0d/%0d/%h exp=5/1/00",
                     ack_k, we_cnt, b_rdata);
        end
        ack_k = 0;
        b_req1 = 1; b_wr1 = 0; b_addr1 = 4'd2;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (k >= 2 && k <= 5 && b_ram_we) we_late++;
            if (b_ack1 && ack_k == 0) begin
                ack_k = k; rd = b_rdata; b_req1 = 0;
            end
        end
        checks++;
        if (ack_k != 5) begin
            failures++;
            $display("FAIL lat3_ack_cycle got=%0d exp=5", ack_k);
        end
        checks++;
        if (rd !== 8'h77 || we_late != 0) begin
            failures++;
            $display("FAIL lat3_read got=%h/%0d exp=77/0", rd, we_late);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_tie(0);
        test_single_read();
        test_tie(1);
        test_reset_mid();
        test_conflict();
        test_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
